// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display showing a per-frame
// snapshot of PC / ALU / debug register, with a one-cycle blank at every digit switch.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       hold,
    input  logic [7:0] pc_value,
    input  logic [7:0] alu_value,
    input  logic [7:0] reg_value,
    input  logic [2:0] reg_sel,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [1:0]      idx_q;
    logic [1:0]      snap_mode_q;
    logic [7:0]      snap_val_q;
    logic [2:0]      snap_sel_q;
    logic [6:0]      seg_q;
    logic [3:0]      an_q;
    logic            frame_start_q;

    logic            tick;
    logic            boundary;
    logic [7:0]      sel_val;
    logic [6:0]      digit_seg;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tick  = (cnt_q == CW'(REFRESH_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    // A frame begins when slot 0 is entered, either from IDLE or by wrapping past digit 3.
    assign boundary = tick && ((state_q == IDLE) || ((state_q == DRIVE) && (idx_q == 2'd3)));

    always_comb begin
        sel_val = 8'h00;
        case (mode)
            2'b00:   sel_val = pc_value;
            2'b01:   sel_val = alu_value;
            2'b10:   sel_val = reg_value;
            default: sel_val = 8'h00;
        endcase
    end

    always_comb begin
        digit_seg = SEG_BLANK;
        if (snap_mode_q != 2'b11) begin
            case (idx_q)
                2'd0: digit_seg = hex7(snap_val_q[3:0]);
                2'd1: digit_seg = hex7(snap_val_q[7:4]);
                2'd2: digit_seg = (snap_mode_q == 2'b10) ? hex7({1'b0, snap_sel_q}) : SEG_BLANK;
                default: begin
                    case (snap_mode_q)
                        2'b00:   digit_seg = SEG_P;
                        2'b01:   digit_seg = SEG_A;
                        default: digit_seg = SEG_R;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= 2'd0;
            snap_mode_q   <= 2'b00;
            snap_val_q    <= 8'h00;
            snap_sel_q    <= 3'd0;
            seg_q         <= SEG_BLANK;
            an_q          <= 4'b1111;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            frame_start_q <= boundary;
            if (boundary && !hold) begin
                snap_mode_q <= mode;
                snap_val_q  <= sel_val;
                snap_sel_q  <= reg_sel;
            end
            case (state_q)
                IDLE: begin
                    seg_q <= SEG_BLANK;
                    an_q  <= 4'b1111;
                    if (tick) begin
                        state_q <= BLANK;
                        idx_q   <= 2'd0;
                    end
                end
                BLANK: begin
                    // Snapshot was captured on the previous edge, so digit_seg already reflects it.
                    state_q <= DRIVE;
                    an_q    <= ~(4'b0001 << idx_q);
                    seg_q   <= digit_seg;
                end
                DRIVE: begin
                    if (tick) begin
                        state_q <= BLANK;
                        idx_q   <= idx_q + 2'd1;
                        an_q    <= 4'b1111;
                        seg_q   <= SEG_BLANK;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    an_q    <= 4'b1111;
                    seg_q   <= SEG_BLANK;
                end
            endcase
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus randomized phases,
// compared cycle by cycle against a time-indexed display model.
module tb_seg_scan_ctrl;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic       hold = 1'b0;
  logic [7:0] pc_value = 8'h00;
  logic [7:0] alu_value = 8'h00;
  logic [7:0] reg_value = 8'h00;
  logic [2:0] reg_sel = 3'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // model state: edges since reset release and the snapshot of the current frame
  int         k_edge;
  logic [1:0] m_mode;
  logic [7:0] m_val;
  logic [2:0] m_sel;
  logic [6:0] hex_tab [16];
  logic [11:0] exp_q[$];

  seg_scan_ctrl #(.REFRESH_DIV(RD)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .hold(hold),
    .pc_value(pc_value),
    .alu_value(alu_value),
    .reg_value(reg_value),
    .reg_sel(reg_sel),
    .seg(seg),
    .an(an),
    .frame_start(frame_start)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // expected {frame_start, an, seg} after edge k, from slot arithmetic
  function automatic logic [11:0] model_out(input int k, input logic [1:0] sm,
                                            input logic [7:0] sv, input logic [2:0] ss);
    int j, slot, pos, d;
    logic [3:0] a;
    logic [6:0] s;
    if (k < RD - 1) return {1'b0, 4'hF, 7'h7F};
    j    = k - (RD - 1);
    slot = j / RD;
    pos  = j % RD;
    d    = slot % 4;
    if (pos == 0) return {(d == 0), 4'hF, 7'h7F};
    a = 4'hF;
    a[d] = 1'b0;
    s = 7'h7F;
    if (sm != 2'b11) begin
      case (d)
        0: s = hex_tab[sv[3:0]];
        1: s = hex_tab[sv[7:4]];
        2: s = (sm == 2'b10) ? hex_tab[{1'b0, ss}] : 7'h7F;
        default: s = (sm == 2'b00) ? 7'b0001100 : (sm == 2'b01) ? 7'b0001000 : 7'b0101111;
      endcase
    end
    return {1'b0, a, s};
  endfunction

  task automatic model_reset();
    k_edge = 0;
    m_mode = 2'b00;
    m_val  = 8'h00;
    m_sel  = 3'd0;
    exp_q.delete();
  endtask

  // driver: advance n cycles; model sees inputs at posedge, outputs checked at negedge
  task automatic run_cycles(input int n);
    logic [11:0] e;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      if (k_edge >= RD - 1 && ((k_edge - (RD - 1)) % (4 * RD)) == 0 && !hold) begin
        m_mode = mode;
        m_sel  = reg_sel;
        case (mode)
          2'b00:   m_val = pc_value;
          2'b01:   m_val = alu_value;
          2'b10:   m_val = reg_value;
          default: m_val = 8'h00;
        endcase
      end
      exp_q.push_back(model_out(k_edge, m_mode, m_val, m_sel));
      k_edge++;
      @(negedge clk);
      e = exp_q.pop_front();
      check("frame_start", {31'd0, frame_start}, {31'd0, e[11]});
      check("an", {28'd0, an}, {28'd0, e[10:7]});
      check("seg", {25'd0, seg}, {25'd0, e[6:0]});
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    model_reset();

    // reset values
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_fs", {31'd0, frame_start}, 32'h0);

    // reset / scan with PC = 3C
    mode = 2'b00;
    pc_value = 8'h3C;
    release_reset();
    run_cycles(4);
    check("scan_idle_an", {28'd0, an}, 32'hF);
    check("scan_fs", {31'd0, frame_start}, 32'h1);
    run_cycles(1);
    check("scan_d0", {21'd0, an, seg}, {21'd0, 4'b1110, 7'b1000110});
    run_cycles(4);
    check("scan_d1", {21'd0, an, seg}, {21'd0, 4'b1101, 7'b0110000});
    run_cycles(4);
    check("scan_d2", {21'd0, an, seg}, {21'd0, 4'b1011, 7'b1111111});
    run_cycles(4);
    check("scan_d3", {21'd0, an, seg}, {21'd0, 4'b0111, 7'b0001100});
    run_cycles(3);

    // register mode: 7, A, 5, r
    mode = 2'b10;
    reg_sel = 3'd5;
    reg_value = 8'hA7;
    run_cycles(32);

    // mid-frame change of ALU value while digit 1 drives
    mode = 2'b01;
    alu_value = 8'h12;
    run_cycles(16 + 6);
    alu_value = 8'hFF;
    run_cycles(26);

    // hold across three frames, then release
    mode = 2'b00;
    pc_value = 8'h5E;
    run_cycles(16);
    hold = 1'b1;
    pc_value = 8'h91;
    run_cycles(48);
    hold = 1'b0;
    run_cycles(32);

    // display off
    mode = 2'b11;
    run_cycles(32);

    // asynchronous reset between edges
    mode = 2'b01;
    alu_value = 8'h4B;
    run_cycles(21);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_an", {28'd0, an}, 32'hF);
    check("arst_seg", {25'd0, seg}, 32'h7F);
    check("arst_fs", {31'd0, frame_start}, 32'h0);
    @(negedge clk);
    release_reset();
    run_cycles(40);

    // randomized phases
    for (int p = 0; p < 60; p++) begin
      mode      = 2'($urandom_range(0, 3));
      hold      = ($urandom_range(0, 3) == 0);
      pc_value  = 8'($urandom);
      alu_value = 8'($urandom);
      reg_value = 8'($urandom);
      reg_sel   = 3'($urandom_range(0, 7));
      run_cycles($urandom_range(1, 24));
    end
    hold = 1'b0;
    run_cycles(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 4-digit, common-anode 7-segment display on the CPU top level. It shares the single `seg` bus among the four digits on a fixed refresh schedule. Each frame it snapshots one of three CPU observation values (PC, ALU output, selected debug register) together with a source tag. It inserts a one-cycle blanking gap at every digit switch to suppress ghosting.

## Interface
Parameters:
- `REFRESH_DIV`, 100000: clocks per digit slot (1 kHz per digit at 100 MHz); minimum 2.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `mode`  in  2  source select: 00 PC, 01 ALU, 10 debug reg, 11 display off
- `hold`  in  1  1 = keep the current snapshot at frame boundaries (freeze)
- `pc_value`  in  8  program counter
- `alu_value`  in  8  ALU result
- `reg_value`  in  8  debug register value
- `reg_sel`  in  3  debug register index
- `seg`  out  7  {g,f,e,d,c,b,a}, active-low, registered
- `an`  out  4  digit enables, active-low, registered; `an[0]` is the rightmost digit
- `frame_start`  out  1  one-cycle pulse when a new frame (digit 0) begins

## Operation
- Prescaler `cnt` counts 0..REFRESH_DIV-1 and wraps. `tick` = (`cnt`==REFRESH_DIV-1).
- FSM states:
  - IDLE: entered on reset.
  - BLANK: lasts one cycle.
  - DRIVE: held until the next `tick`.
- IDLE --tick--> BLANK, with `idx` set to 0 and a frame boundary.
- DRIVE --tick--> BLANK, with `idx` <- `idx`+1 mod 4. The frame boundary occurs when `idx` wraps 3->0.
- BLANK --> DRIVE unconditionally on the next cycle.
- At each frame boundary:
  - If `hold`=0: `snap_mode`, `snap_val`, `snap_sel` <- `mode`, the selected value, `reg_sel`.
  - If `hold`=1: the snapshot is unchanged.
  - `frame_start`=1 for that cycle, regardless of `hold`.
- The selected value is `pc_value` (mode 00), `alu_value` (01), `reg_value` (10), or 0 (11).
- Digit contents from the snapshot:
  - idx0: `snap_val[3:0]` in hex.
  - idx1: `snap_val[7:4]` in hex.
  - idx2: `snap_sel` in hex when `snap_mode`=10, otherwise blank.
  - idx3: tag P / A / r for `snap_mode` 00 / 01 / 10.
  - `snap_mode`=11: all four digits blank, but `an` still scans.
- Output values per state:
  - BLANK: `an`=1111, `seg`=1111111.
  - DRIVE: `an`=~(1<<`idx`), `seg`=encode(digit).
  - IDLE: `an`=1111, `seg`=1111111.
- Hex encodings:
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000
  - 4 0011001, 5 0010010, 6 0000010, 7 1111000
  - 8 0000000, 9 0010000, A 0001000, b 0000011
  - C 1000110, d 0100001, E 0000110, F 0001110
- Tag and blank encodings: P 0001100, r 0101111, blank 1111111.
- Changes to `mode`, `reg_sel` or any value input mid-frame have no visible effect until the next frame boundary. There is no tearing.

## Timing
- Reset values (asynchronous): state IDLE, `cnt`=0, `idx`=0, snapshot all 0 (mode 00), `an`=1111, `seg`=1111111, `frame_start`=0.
- `rst` asserted mid-frame returns the outputs to reset values immediately, without waiting for a clock.
- Reset release at edge E0:
  - The first `tick` is the edge with `cnt`=REFRESH_DIV-1, i.e. REFRESH_DIV edges after E0.
  - BLANK outputs appear after that edge.
  - Digit 0 drives one cycle later.
- Per-slot timing: each slot is REFRESH_DIV cycles long, made of 1 BLANK cycle followed by REFRESH_DIV-1 DRIVE cycles.
- Frame period is 4·REFRESH_DIV cycles.
- Snapshot inputs are sampled on the tick edge that enters BLANK for digit 0. Digit 0 of the new snapshot appears 1 cycle after that.
- `frame_start` is high during the BLANK cycle of digit 0.
- With `hold` toggled on the same edge as a frame boundary, the sampled `hold` value decides whether the snapshot updates.

## Test plan
(All scenarios use REFRESH_DIV=4.)
- Reset/scan: release `rst`, hold `mode`=00, `pc_value`=8'h3C.
  - `an`=1111 for the first 4 cycles, then 1110 with `seg`=1000110 (C).
  - Then 1101 with `seg`=0110000 (3), 1011 with `seg`=1111111, 0111 with `seg`=0001100 (P).
  - Each digit shows for 3 cycles after a 1-cycle blank.
- Reg mode: `mode`=10, `reg_sel`=5, `reg_value`=8'hA7.
  - Digits 0..3 show 7 (1111000), A (0001000), 5 (0010010), r (0101111).
- Mid-frame change: while digit 1 is driving, change `alu_value` 8'h12->8'hFF with `mode`=01.
  - The rest of the frame still shows 1/2 and A.
  - The next frame shows F, F.
- Hold: set `hold`=1, then change `pc_value`.
  - The display keeps the old value across 3 frames.
  - `frame_start` still pulses every 16 cycles.
  - On release, the new value appears after the next boundary.
- Off mode and async reset:
  - `mode`=11 gives `seg`=1111111 on all slots while `an` keeps rotating.
  - Asserting `rst` between clock edges forces `an`=1111 and `seg`=1111111 immediately.
